// File: rtl/logIP_pkg.sv
// Shared definitions for the SUMP command path.
// Contents:
//   cmd_state_t   - command sequencer FSM states (IDLE, ARG)
//   CMD_LONG_BIT  - opcode bit that marks a long (argument-carrying) command
//   CMD_ARG_BYTES - number of argument bytes following a long opcode
package logIP_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ARG  = 1'b1
  } cmd_state_t;

  localparam int CMD_LONG_BIT  = 7;
  localparam int CMD_ARG_BYTES = 4;

endpackage

// File: rtl/cmd_ctrl_tmo_cnt.sv
// tmo_cnt: inter-byte timeout down-counter.
// Loaded with TIMEOUT_CYC-1 on every received byte, it decrements while
// enabled and flags expiry in the last cycle before the timeout must take
// effect, so the owner can register its reaction on the following edge.
// Ports:
//   clk_i  in  system clock
//   rst_in in  asynchronous active-low reset
//   clr_i  in  force the count to zero (highest priority)
//   load_i in  reload the full timeout window
//   en_i   in  count down one step
//   exp_o  out expiry: enabled and the window ends at the next edge
module tmo_cnt #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic clk_i,
  input  logic rst_in,
  input  logic clr_i,
  input  logic load_i,
  input  logic en_i,
  output logic exp_o
);

  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL =
    (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (en_i && (cnt_q != '0)) begin
      // Saturate at zero rather than wrapping.
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A value of 1 (or 0 for a one-cycle window) means the window closes
  // at the coming edge; a zero TIMEOUT_CYC disables expiry entirely.
  assign exp_o = (TIMEOUT_CYC > 0) && en_i && (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/cmd_ctrl.sv
// cmd_ctrl: SUMP command sequencer between the UART receiver and the
// instruction decoder. Assembles short (1 byte) and long (opcode + 4
// little-endian argument bytes) commands and presents each completed
// command with a one-cycle execute strobe.
// Ports:
//   clk_i    in   system clock
//   rst_in   in   asynchronous active-low reset
//   rx_stb_i in   received byte valid (one-cycle pulse)
//   rx_dat_i in   received byte
//   exec_o   out  one-cycle pulse, opc_o/arg_o hold a complete command
//   opc_o    out  opcode of the last completed command
//   arg_o    out  argument of the last completed long command
//   busy_o   out  argument bytes are being collected
//   err_o    out  one-cycle pulse, partial long command dropped by timeout
module cmd_ctrl
  import logIP_pkg::*;
#(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic        clk_i,
  input  logic        rst_in,
  input  logic        rx_stb_i,
  input  logic [7:0]  rx_dat_i,
  output logic        exec_o,
  output logic [7:0]  opc_o,
  output logic [31:0] arg_o,
  output logic        busy_o,
  output logic        err_o
);

  cmd_state_t  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  opc_q, opc_d;
  logic [31:0] arg_q, arg_d;
  logic [7:0]  opc_out_q, opc_out_d;
  logic [31:0] arg_out_q, arg_out_d;
  logic        exec_q, exec_d;
  logic        err_q, err_d;
  logic        tmo_en, tmo_exp;

  // Count only while waiting for an argument byte; any byte reloads the
  // window, and the counter is parked at zero whenever we are idle.
  assign tmo_en = (state_q == ARG) && !rx_stb_i;

  tmo_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_tmo_cnt (
    .clk_i (clk_i),
    .rst_in(rst_in),
    .clr_i (state_d == IDLE),
    .load_i(rx_stb_i),
    .en_i  (tmo_en),
    .exp_o (tmo_exp)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    opc_d     = opc_q;
    arg_d     = arg_q;
    opc_out_d = opc_out_q;
    arg_out_d = arg_out_q;
    exec_d    = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rx_stb_i) begin
          if (rx_dat_i[CMD_LONG_BIT]) begin
            opc_d   = rx_dat_i;
            cnt_d   = 2'd0;
            state_d = ARG;
          end else begin
            opc_out_d = rx_dat_i;
            exec_d    = 1'b1;
          end
        end
      end
      ARG: begin
        // A byte in the expiry cycle takes precedence over the timeout.
        if (rx_stb_i) begin
          arg_d[8*cnt_q +: 8] = rx_dat_i;
          cnt_d               = cnt_q + 2'd1;
          if (cnt_q == 2'(CMD_ARG_BYTES - 1)) begin
            opc_out_d = opc_q;
            arg_out_d = arg_d;
            exec_d    = 1'b1;
            state_d   = IDLE;
          end
        end else if (tmo_exp) begin
          arg_d   = '0;
          cnt_d   = 2'd0;
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= IDLE;
      cnt_q     <= 2'd0;
      opc_q     <= 8'h00;
      arg_q     <= 32'h0;
      opc_out_q <= 8'h00;
      arg_out_q <= 32'h0;
      exec_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      opc_q     <= opc_d;
      arg_q     <= arg_d;
      opc_out_q <= opc_out_d;
      arg_out_q <= arg_out_d;
      exec_q    <= exec_d;
      err_q     <= err_d;
    end
  end

  assign exec_o = exec_q;
  assign err_o  = err_q;
  assign opc_o  = opc_out_q;
  assign arg_o  = arg_out_q;
  assign busy_o = (state_q == ARG);

endmodule

// File: tb/tb_cmd_ctrl.sv
// Scoreboard bench for cmd_ctrl with a short inter-byte timeout.
module tb_cmd_ctrl;
  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rx_stb = 1'b0;
  logic [7:0]  rx_dat = 8'h00;
  logic        exec, err, busy;
  logic [7:0]  opc;
  logic [31:0] arg;

  cmd_ctrl #(.TIMEOUT_CYC(T)) dut (
    .clk_i   (clk),
    .rst_in  (rst_n),
    .rx_stb_i(rx_stb),
    .rx_dat_i(rx_dat),
    .exec_o  (exec),
    .opc_o   (opc),
    .arg_o   (arg),
    .busy_o  (busy),
    .err_o   (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_err;
    int          at;
    logic [7:0]  opc;
    logic [31:0] arg;
  } ev_t;

  ev_t q[$];
  int tests = 0;
  int fails = 0;

  // Reference model: pending long command as opcode + list of bytes seen.
  bit          pend = 1'b0;
  logic [7:0]  m_opc = 8'h00;
  logic [7:0]  m_bytes[$];
  int          m_last = 0;
  logic [31:0] m_arg_vis = 32'h0;
  bit          exp_busy = 1'b0;
  logic [7:0]  cur_opc = 8'h00;
  logic [31:0] cur_arg = 32'h0;
  bit          chk_en = 1'b0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle (byte or idle) and advance the reference model.
  task automatic step(bit stb, logic [7:0] d);
    int c = cyc;
    if (pend && (c - m_last >= T)) begin
      q.push_back('{1'b1, m_last + T, 8'h00, 32'h0});
      pend = 1'b0;
      m_bytes.delete();
    end
    exp_busy = pend;
    rx_stb = stb;
    rx_dat = d;
    if (stb) begin
      if (pend) begin
        m_bytes.push_back(d);
        m_last = c;
        if (m_bytes.size() == 4) begin
          m_arg_vis = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
          q.push_back('{1'b0, c + 1, m_opc, m_arg_vis});
          pend = 1'b0;
          m_bytes.delete();
        end
      end else if (d >= 8'h80) begin
        pend = 1'b1;
        m_opc = d;
        m_bytes.delete();
        m_last = c;
      end else begin
        q.push_back('{1'b0, c + 1, d, m_arg_vis});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) step(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_exec", exec, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_opc", opc, 8'h00);
    check("rst_arg", arg, 32'h0);
    rx_stb = 1'b0;
    pend = 1'b0;
    m_bytes.delete();
    q.delete();
    m_arg_vis = 32'h0;
    cur_opc = 8'h00;
    cur_arg = 32'h0;
    exp_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: pops expected strobes and checks levels every cycle.
  always @(negedge clk) begin : mon
    ev_t e;
    if (chk_en && rst_n) begin
      check("busy_o", busy, exp_busy);
      while (q.size() > 0 && q[0].at < cyc) begin
        tests++;
        fails++;
        $display("FAIL missing_event: %s expected at cycle %0d, not seen by %0d",
                 q[0].is_err ? "err" : "exec", q[0].at, cyc);
        void'(q.pop_front());
      end
      if (exec || err) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_strobe at cycle %0d: exec=%0b err=%0b expected none",
                   cyc, exec, err);
        end else begin
          e = q.pop_front();
          check("event_cycle", cyc, e.at);
          check("err_o", err, e.is_err);
          check("exec_o", exec, !e.is_err);
          if (!e.is_err) begin
            check("opc_o", opc, e.opc);
            check("arg_o", arg, e.arg);
            cur_opc = e.opc;
            cur_arg = e.arg;
          end else begin
            check("opc_hold_err", opc, cur_opc);
            check("arg_hold_err", arg, cur_arg);
          end
        end
      end else begin
        check("opc_hold", opc, cur_opc);
        check("arg_hold", arg, cur_arg);
      end
    end
  end

  initial begin
    int gap;
    do_reset();
    chk_en = 1'b1;

    // Short command
    step(1'b1, 8'h01);
    idle(3);

    // Long command with 3-cycle gaps
    step(1'b1, 8'hC0);
    foreach (m_opc[i]) begin end
    idle(3); step(1'b1, 8'h11);
    idle(3); step(1'b1, 8'h22);
    idle(3); step(1'b1, 8'h33);
    idle(3); step(1'b1, 8'h44);
    idle(3);

    // Timeout, then a short command
    step(1'b1, 8'h80);
    step(1'b1, 8'hAA);
    step(1'b1, 8'hBB);
    idle(T + 3);
    step(1'b1, 8'h02);
    idle(3);

    // Back-to-back traffic
    step(1'b1, 8'h81);
    repeat (4) step(1'b1, 8'h5A);
    step(1'b1, 8'h11);
    idle(3);

    // Resynchronisation with soft-reset bytes
    step(1'b1, 8'hC0);
    step(1'b1, 8'h01);
    repeat (5) step(1'b1, 8'h00);
    idle(3);

    // Timeout boundary: byte in the expiry cycle is accepted
    step(1'b1, 8'h80);
    idle(T - 2);
    step(1'b1, 8'h33);
    step(1'b1, 8'h44);
    step(1'b1, 8'h55);
    step(1'b1, 8'h66);
    idle(3);

    // One cycle later the timeout has already fired
    step(1'b1, 8'h80);
    idle(T - 1);
    step(1'b1, 8'h05);
    idle(3);

    // Reset in the middle of a long command
    step(1'b1, 8'hC2);
    step(1'b1, 8'h01);
    step(1'b1, 8'h02);
    do_reset();
    step(1'b1, 8'h02);
    idle(3);

    // Randomised traffic with gaps around the timeout window
    repeat (300) begin
      case ($urandom_range(0, 7))
        0, 1:    gap = 0;
        2:       gap = 1;
        3:       gap = 2;
        4:       gap = T - 2;
        5:       gap = T - 1;
        6:       gap = T;
        default: gap = T + 4;
      endcase
      idle(gap);
      step(1'b1, 8'($urandom_range(0, 255)));
    end

    idle(T + 5);
    check("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
